// File: rtl/shift_exec_unit.sv
// Execute-stage shift sequencer for RV64I: SLL/SRL/SRA and their W forms. It takes
// one operation over valid/ready and holds the registered result until writeback takes it.
module shift_exec_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_illegal,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_SLL = 2'd0,
    K_SRL = 2'd1,
    K_SRA = 2'd2,
    K_BAD = 2'd3
  } kind_t;

  state_t state, state_nxt;

  logic            phase;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [5:0]      b_q;
  logic [XLEN-1:0] mid_q;

  logic capture, exec_last, handoff;

  logic            word_op, right_op, arith_op, illegal_op;
  kind_t           kind;
  logic [5:0]      shamt;
  logic [XLEN-1:0] src, core_in, mid, core_out, shifted, result_nxt;
  logic            fill;

  // Only the low six bits of rs2/imm ever reach the shifter.
  logic unused_b_hi;
  assign unused_b_hi = ^in_b[XLEN-1:6];

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    // NOTE: inside functions and always_comb, blocking '=' is correct; '<=' belongs only to clocked state.
    r = '0;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  // Three log-shifter levels of 2**base, 2**(base+1), 2**(base+2) positions.
  function automatic logic [XLEN-1:0] shl_stages(input logic [XLEN-1:0] v,
                                                 input logic [2:0]      sh,
                                                 input int              base,
                                                 input logic            fill_bit);
    logic [XLEN-1:0] t;
    int amt;
    t = v;
    for (int s = 0; s < 3; s++) begin
      amt = 1 << (base + s);
      if (sh[s]) t = (t << amt) | ({XLEN{fill_bit}} & ~({XLEN{1'b1}} << amt));
    end
    return t;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    exec_last = 1'b0;
    handoff   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (phase) begin
          exec_last = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      capture   = 1'b0;
      exec_last = 1'b0;
      handoff   = 1'b0;
    end
  end

  // Right shifts reuse the left shifter on a bit-reversed operand; the shifter is
  // split over the two EXEC cycles, low three levels first.
  always_comb begin
    kind       = kind_t'(op_q[1:0]);
    word_op    = op_q[2];
    illegal_op = (kind == K_BAD);
    right_op   = (kind == K_SRL) || (kind == K_SRA);
    arith_op   = (kind == K_SRA);
    shamt      = word_op ? {1'b0, b_q[4:0]} : b_q;

    if (word_op)
      src = arith_op ? {{(XLEN-32){a_q[31]}}, a_q[31:0]} : {{(XLEN-32){1'b0}}, a_q[31:0]};
    else
      src = a_q;
    fill = arith_op & src[XLEN-1];

    core_in  = right_op ? bit_rev(src) : src;
    mid      = shl_stages(core_in, shamt[2:0], 0, fill);
    core_out = shl_stages(mid_q, shamt[5:3], 3, fill);
    shifted  = right_op ? bit_rev(core_out) : core_out;

    if (illegal_op)
      result_nxt = '0;
    else if (word_op)
      result_nxt = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
    else
      result_nxt = shifted;
  end

  // NOTE: every register, datapath included, is cleared by the async reset so outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mid_q       <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      done_count  <= '0;
    end else begin
      state <= state_nxt;
      phase <= (state == EXEC) && !phase && !flush;
      if (capture) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b[5:0];
      end
      if ((state == EXEC) && !phase) mid_q <= mid;
      if (exec_last) begin
        out_result  <= result_nxt;
        out_illegal <= illegal_op;
      end
      if (handoff) done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit: a behavioural shift model queues expected
// results at issue; they are popped and compared when the unit raises out_valid.
module tb_shift_exec_unit;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b, out_result;
  logic [CNT_W-1:0] done_count;

  typedef struct packed {
    logic            illegal;
    logic [XLEN-1:0] result;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_count = '0;

  shift_exec_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .done_count(done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [31:0] a32, w;
    a32 = a[31:0];
    w   = '0;
    e.illegal = 1'b0;
    e.result  = '0;
    case (op)
      3'b000: e.result = a << b[5:0];
      3'b001: e.result = a >> b[5:0];
      3'b010: e.result = $signed(a) >>> b[5:0];
      3'b100: w = a32 << b[4:0];
      3'b101: w = a32 >> b[4:0];
      3'b110: w = $signed(a32) >>> b[4:0];
      default: e.illegal = 1'b1;
    endcase
    if (op[2] && !e.illegal) e.result = {{32{w[31]}}, w};
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    exp_t e;
    int   n;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    sb.push_back(model(op, a, b));
    tick();
    in_valid = 1'b0;
    in_op = 3'($urandom); in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, 2);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("result", out_result, e.result);
    check("illegal", out_illegal, e.illegal);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_op = 3'b000; in_a = {$urandom, $urandom}; in_b = 64'd1;
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_result", out_result, e.result);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count++;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("done_count", done_count, exp_count);
  endtask

  initial begin
    exp_t e;
    logic [63:0] bsel [5];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_count", done_count, 0);

    run_op(3'b000, 64'h1, 64'h3F, 0);
    run_op(3'b010, 64'h8000000000000000, 64'h44, 0);
    run_op(3'b001, 64'h8000000000000000, 64'h44, 0);
    run_op(3'b100, 64'h1, 64'h1F, 0);
    run_op(3'b101, 64'hFFFFFFFF80000000, 64'h21, 0);
    run_op(3'b110, 64'hFFFFFFFF80000000, 64'h21, 0);
    run_op(3'b011, 64'hDEADBEEFCAFEF00D, 64'h5, 0);
    run_op(3'b111, 64'h123456789ABCDEF0, 64'h3, 0);
    run_op(3'b000, 64'h00000000000000FF, 64'h0, 0);
    run_op(3'b100, 64'hFFFFFFFF7FFFFFFF, 64'h20, 0);
    run_op(3'b010, 64'hF0F0F0F00F0F0F0F, 64'h7, 5);

    // Flush while the operation is in EXEC.
    in_valid = 1'b1; in_op = 3'b000; in_a = 64'h5; in_b = 64'h2;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        seen |= out_valid;
        tick();
      end
      check("flush_exec_no_valid", seen, 0);
    end
    check("flush_exec_count", done_count, exp_count);
    check("flush_exec_ready", in_ready, 1);

    // Flush beats a simultaneous in_valid in IDLE.
    in_valid = 1'b1; flush = 1'b1; in_op = 3'b001; in_a = 64'hFF; in_b = 64'h1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        seen |= out_valid;
        tick();
      end
      check("flush_idle_no_valid", seen, 0);
    end

    // Flush beats out_ready in DONE; result value is retained.
    e = model(3'b000, 64'h1, 64'h1);
    in_valid = 1'b1; in_op = 3'b000; in_a = 64'h1; in_b = 64'h1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("flush_done_pre_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_count", done_count, exp_count);
    check("flush_done_result", out_result, e.result);

    // Async reset in the middle of EXEC.
    in_valid = 1'b1; in_op = 3'b010; in_a = 64'h8000000000000000; in_b = 64'h3;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("amid_rst_valid", out_valid, 0);
    check("amid_rst_result", out_result, 0);
    check("amid_rst_count", done_count, 0);
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op(3'b101, 64'h00000000F0000000, 64'h4, 0);

    // Random mix with boundary shift amounts; long enough to wrap done_count.
    for (int i = 0; i < 20; i++) begin
      bsel[0] = 64'd0; bsel[1] = 64'd31; bsel[2] = 64'd32; bsel[3] = 64'd63;
      bsel[4] = {$urandom, $urandom};
      run_op(3'($urandom), {$urandom, $urandom}, bsel[$urandom_range(0, 4)], i % 3);
    end

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
